// File: rtl/vga_sync_gen_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : vga_timing_pkg
// Description : Default 640x480@60 timing constants, derived totals, sync
//               window bounds and the coordinate type for vga_sync_gen.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    localparam int CD_DEF       = 11;
    localparam int HD_DEF       = 640;
    localparam int HF_DEF       = 16;
    localparam int HR_DEF       = 96;
    localparam int HB_DEF       = 48;
    localparam int VD_DEF       = 480;
    localparam int VF_DEF       = 10;
    localparam int VR_DEF       = 2;
    localparam int VB_DEF       = 33;
    localparam int CLK_DIV_DEF  = 4;
    localparam int SYNC_DLY_DEF = 2;

    // Derived totals for the default mode
    localparam int HT_DEF = HD_DEF + HF_DEF + HR_DEF + HB_DEF;
    localparam int VT_DEF = VD_DEF + VF_DEF + VR_DEF + VB_DEF;

    // Inclusive sync windows for the default mode
    localparam int HS_START_DEF = HD_DEF + HF_DEF;
    localparam int HS_END_DEF   = HD_DEF + HF_DEF + HR_DEF - 1;
    localparam int VS_START_DEF = VD_DEF + VF_DEF;
    localparam int VS_END_DEF   = VD_DEF + VF_DEF + VR_DEF - 1;

    typedef logic [CD_DEF-1:0] coord_t;

    // Divider counter width; never below one bit
    function automatic int div_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage : vga_timing_pkg
`default_nettype wire

// File: rtl/vga_sync_gen_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : vga_sync_gen_if
// Description : Timing bundle between the sync generator (master) and the
//               frame cores consuming coordinates and sync (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_sync_gen_if
    import vga_timing_pkg::*;
#(
    parameter int CD = CD_DEF
);
    logic          en;
    logic [CD-1:0] x;
    logic [CD-1:0] y;
    logic          p_tick;
    logic          video_on;
    logic          hsync;
    logic          vsync;
    logic          sof;
    logic          hsync_d;
    logic          vsync_d;
    logic          video_on_d;

    modport master (
        input  en,
        output x, y, p_tick, video_on, hsync, vsync, sof,
               hsync_d, vsync_d, video_on_d
    );

    modport slave (
        output en,
        input  x, y, p_tick, video_on, hsync, vsync, sof,
               hsync_d, vsync_d, video_on_d
    );

endinterface : vga_sync_gen_if
`default_nettype wire

// File: rtl/vga_sync_gen_sync_delay.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sync_delay
// Description : DEPTH-stage shift register with a per-bit reset value.
//               DEPTH=0 is a combinational pass-through.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_delay
    import vga_timing_pkg::*;
#(
    parameter int               WIDTH   = 3,
    parameter int               DEPTH   = SYNC_DLY_DEF,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  wire               clk,
    input  wire               reset_n,
    input  wire  [WIDTH-1:0]  din,
    output logic [WIDTH-1:0]  dout
);

    if (DEPTH == 0) begin : g_bypass
        // Clock and reset are not needed without stages
        wire unused_bypass = clk ^ reset_n;
        assign dout = din;
    end else begin : g_shift
        logic [WIDTH-1:0] stage [DEPTH];

        // Shift one stage per clock; reset loads every stage with RST_VAL
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stage[i] <= RST_VAL;
                end
            end else begin
                stage[0] <= din;
                for (int i = 1; i < DEPTH; i++) begin
                    stage[i] <= stage[i-1];
                end
            end
        end

        assign dout = stage[DEPTH-1];
    end

endmodule : sync_delay
`default_nettype wire

// File: rtl/vga_sync_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : vga_sync_gen
// Description : Video timing generator. Divides clk into a pixel tick, runs
//               horizontal/vertical counters and produces registered
//               video_on/hsync/vsync/sof plus a delayed sync/blank copy.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int CD       = CD_DEF,
    parameter int HD       = HD_DEF,
    parameter int HF       = HF_DEF,
    parameter int HR       = HR_DEF,
    parameter int HB       = HB_DEF,
    parameter int VD       = VD_DEF,
    parameter int VF       = VF_DEF,
    parameter int VR       = VR_DEF,
    parameter int VB       = VB_DEF,
    parameter int CLK_DIV  = CLK_DIV_DEF,
    parameter int SYNC_DLY = SYNC_DLY_DEF
) (
    input  wire            clk,
    input  wire            reset_n,
    vga_sync_gen_if.master vga
);

    localparam int HT = HD + HF + HR + HB;
    localparam int VT = VD + VF + VR + VB;
    localparam int DW = div_width(CLK_DIV);

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [CD-1:0] X_LAST   = CD'(HT - 1);
    localparam logic [CD-1:0] Y_LAST   = CD'(VT - 1);
    localparam logic [CD-1:0] X_VIS    = CD'(HD);
    localparam logic [CD-1:0] Y_VIS    = CD'(VD);
    localparam logic [CD-1:0] HS_LO    = CD'(HD + HF);
    localparam logic [CD-1:0] HS_HI    = CD'(HD + HF + HR - 1);
    localparam logic [CD-1:0] VS_LO    = CD'(VD + VF);
    localparam logic [CD-1:0] VS_HI    = CD'(VD + VF + VR - 1);

    // Elaboration-time parameter sanity checks
    if ((HT - 1) >= (2 ** CD) || (VT - 1) >= (2 ** CD)) begin : g_err_cd
        $error("vga_sync_gen: CD=%0d cannot hold HT-1=%0d / VT-1=%0d", CD, HT - 1, VT - 1);
    end
    if (CLK_DIV < 2) begin : g_err_div
        $error("vga_sync_gen: CLK_DIV=%0d must be at least 2", CLK_DIV);
    end
    if (SYNC_DLY < 0 || SYNC_DLY > 7) begin : g_err_dly
        $error("vga_sync_gen: SYNC_DLY=%0d outside 0..7", SYNC_DLY);
    end

    logic [DW-1:0] div_cnt;
    logic [CD-1:0] x_cnt;
    logic [CD-1:0] y_cnt;
    logic [CD-1:0] x_next;
    logic [CD-1:0] y_next;
    logic          running;
    logic          vid_reg;
    logic          hs_reg;
    logic          vs_reg;
    logic          sof_reg;
    logic          p_tick;
    logic [2:0]    sync_d;

    assign p_tick = vga.en && (div_cnt == DIV_LAST);

    // Next counter position; outputs are decoded from it so they line up with x/y
    always_comb begin
        x_next = x_cnt;
        y_next = y_cnt;
        if (p_tick) begin
            if (x_cnt == X_LAST) begin
                x_next = '0;
                y_next = (y_cnt == Y_LAST) ? '0 : y_cnt + CD'(1);
            end else begin
                x_next = x_cnt + CD'(1);
            end
        end
    end

    // Counters and registered decode; en low drops straight back to idle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            x_cnt   <= '0;
            y_cnt   <= '0;
            running <= 1'b0;
            vid_reg <= 1'b0;
            hs_reg  <= 1'b1;
            vs_reg  <= 1'b1;
            sof_reg <= 1'b0;
        end else if (!vga.en) begin
            div_cnt <= '0;
            x_cnt   <= '0;
            y_cnt   <= '0;
            running <= 1'b0;
            vid_reg <= 1'b0;
            hs_reg  <= 1'b1;
            vs_reg  <= 1'b1;
            sof_reg <= 1'b0;
        end else begin
            // The start edge keeps div at 0 so pixel (0,0) gets a full period
            div_cnt <= (running && !p_tick) ? div_cnt + DW'(1) : '0;
            x_cnt   <= x_next;
            y_cnt   <= y_next;
            running <= 1'b1;
            vid_reg <= (x_next < X_VIS) && (y_next < Y_VIS);
            hs_reg  <= !((x_next >= HS_LO) && (x_next <= HS_HI));
            vs_reg  <= !((y_next >= VS_LO) && (y_next <= VS_HI));
            sof_reg <= !running || (p_tick && (x_cnt == X_LAST) && (y_cnt == Y_LAST));
        end
    end

    sync_delay #(
        .WIDTH   (3),
        .DEPTH   (SYNC_DLY),
        .RST_VAL (3'b110)
    ) u_sync_delay (
        .clk     (clk),
        .reset_n (reset_n),
        .din     ({hs_reg, vs_reg, vid_reg}),
        .dout    (sync_d)
    );

    assign vga.x          = x_cnt;
    assign vga.y          = y_cnt;
    assign vga.p_tick     = p_tick;
    assign vga.video_on   = vid_reg;
    assign vga.hsync      = hs_reg;
    assign vga.vsync      = vs_reg;
    assign vga.sof        = sof_reg;
    assign vga.hsync_d    = sync_d[2];
    assign vga.vsync_d    = sync_d[1];
    assign vga.video_on_d = sync_d[0];

endmodule : vga_sync_gen
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_vga_sync_gen
// Description : Self-checking bench. Instance A uses the default 640x480
//               timing with SYNC_DLY=2; instance B uses a tiny mode with
//               SYNC_DLY=0 so whole frames fit in a short run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_sync_gen;

    localparam int A_HD = 640, A_HF = 16, A_HR = 96, A_HB = 48;
    localparam int A_VD = 480, A_VF = 10, A_VR = 2,  A_VB = 33;
    localparam int A_DIV = 4, A_DLY = 2;

    localparam int B_CD = 6;
    localparam int B_HD = 10, B_HF = 2, B_HR = 3, B_HB = 2;
    localparam int B_VD = 6,  B_VF = 1, B_VR = 2, B_VB = 1;
    localparam int B_DIV = 3, B_DLY = 0;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic        pt;
        logic        vo;
        logic        hs;
        logic        vs;
        logic        sof;
        logic        hsd;
        logic        vsd;
        logic        vod;
    } exp_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    vga_sync_gen_if #(.CD(11))   ifa ();
    vga_sync_gen_if #(.CD(B_CD)) ifb ();

    vga_sync_gen #(
        .CD(11), .HD(A_HD), .HF(A_HF), .HR(A_HR), .HB(A_HB),
        .VD(A_VD), .VF(A_VF), .VR(A_VR), .VB(A_VB),
        .CLK_DIV(A_DIV), .SYNC_DLY(A_DLY)
    ) u_dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .vga     (ifa.master)
    );

    vga_sync_gen #(
        .CD(B_CD), .HD(B_HD), .HF(B_HF), .HR(B_HR), .HB(B_HB),
        .VD(B_VD), .VF(B_VF), .VR(B_VR), .VB(B_VB),
        .CLK_DIV(B_DIV), .SYNC_DLY(B_DLY)
    ) u_dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .vga     (ifb.master)
    );

    // Reference: t = clocks since the start edge, -1 when idle
    function automatic exp_t calc(input int t, input int hd, input int hf, input int hr,
                                  input int hb, input int vd, input int vf, input int vr,
                                  input int vb, input int cdiv);
        exp_t e;
        int   ht, vt, pix, xx, yy;
        e    = '0;
        e.hs = 1'b1;
        e.vs = 1'b1;
        if (t >= 0) begin
            ht    = hd + hf + hr + hb;
            vt    = vd + vf + vr + vb;
            pix   = t / cdiv;
            xx    = pix % ht;
            yy    = (pix / ht) % vt;
            e.x   = 11'(xx);
            e.y   = 11'(yy);
            e.pt  = (t % cdiv) == (cdiv - 1);
            e.vo  = (xx < hd) && (yy < vd);
            e.hs  = !((xx >= hd + hf) && (xx < hd + hf + hr));
            e.vs  = !((yy >= vd + vf) && (yy < vd + vf + vr));
            e.sof = (t % (ht * vt * cdiv)) == 0;
        end
        return e;
    endfunction

    int         ta = -1;
    int         tb = -1;
    exp_t       qa[$];
    exp_t       qb[$];
    logic [2:0] ha[$];
    logic [2:0] hb[$];

    // Scoreboard producer for A: one expected record per clock
    always @(posedge clk or negedge reset_n) begin : m_a
        exp_t e;
        if (!reset_n) begin
            ta = -1;
            ha.delete();
            qa.delete();
            for (int i = 0; i < 8; i++) ha.push_back(3'b110);
        end else begin
            ta = ifa.en ? ta + 1 : -1;
        end
        e = calc(ta, A_HD, A_HF, A_HR, A_HB, A_VD, A_VF, A_VR, A_VB, A_DIV);
        if (reset_n) begin
            ha.push_back({e.hs, e.vs, e.vo});
            if (ha.size() > 8) void'(ha.pop_front());
        end
        {e.hsd, e.vsd, e.vod} = ha[ha.size() - 1 - A_DLY];
        qa.push_back(e);
    end

    // Scoreboard producer for B
    always @(posedge clk or negedge reset_n) begin : m_b
        exp_t e;
        if (!reset_n) begin
            tb = -1;
            hb.delete();
            qb.delete();
            for (int i = 0; i < 8; i++) hb.push_back(3'b110);
        end else begin
            tb = ifb.en ? tb + 1 : -1;
        end
        e = calc(tb, B_HD, B_HF, B_HR, B_HB, B_VD, B_VF, B_VR, B_VB, B_DIV);
        if (reset_n) begin
            hb.push_back({e.hs, e.vs, e.vo});
            if (hb.size() > 8) void'(hb.pop_front());
        end
        {e.hsd, e.vsd, e.vod} = hb[hb.size() - 1 - B_DLY];
        qb.push_back(e);
    end

    // Scoreboard consumer: pop and compare on the falling edge
    always @(negedge clk) begin : sb_chk
        exp_t e;
        exp_t act;
        if (qa.size() > 0) begin
            e    = qa.pop_front();
            e.pt = e.pt & ifa.en;
            act  = {ifa.x, ifa.y, ifa.p_tick, ifa.video_on, ifa.hsync, ifa.vsync,
                    ifa.sof, ifa.hsync_d, ifa.vsync_d, ifa.video_on_d};
            checks++;
            if (act !== e) begin
                failures++;
                $display("FAIL sb_a t=%0d actual=%h required=%h", ta, act, e);
            end
        end
        if (qb.size() > 0) begin
            e    = qb.pop_front();
            e.pt = e.pt & ifb.en;
            act  = {5'd0, ifb.x, 5'd0, ifb.y, ifb.p_tick, ifb.video_on, ifb.hsync, ifb.vsync,
                    ifb.sof, ifb.hsync_d, ifb.vsync_d, ifb.video_on_d};
            checks++;
            if (act !== e) begin
                failures++;
                $display("FAIL sb_b t=%0d actual=%h required=%h", tb, act, e);
            end
        end
    end

    task automatic test_reset();
        reset_n = 1'b0;
        ifa.en  = 1'b0;
        ifb.en  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({ifa.x, ifa.y} !== 22'd0) begin
            failures++;
            $display("FAIL reset_xy actual=%0d,%0d required=0,0", ifa.x, ifa.y);
        end
        checks++;
        if ({ifa.hsync, ifa.vsync, ifa.video_on, ifa.sof, ifa.p_tick} !== 5'b11000) begin
            failures++;
            $display("FAIL reset_flags actual=%b required=11000",
                     {ifa.hsync, ifa.vsync, ifa.video_on, ifa.sof, ifa.p_tick});
        end
        checks++;
        if ({ifa.hsync_d, ifa.vsync_d, ifa.video_on_d} !== 3'b110) begin
            failures++;
            $display("FAIL reset_dly actual=%b required=110",
                     {ifa.hsync_d, ifa.vsync_d, ifa.video_on_d});
        end
        #2 reset_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({ifb.x, ifb.y, ifb.video_on, ifb.hsync, ifb.vsync} !== {12'd0, 3'b011}) begin
            failures++;
            $display("FAIL idle_b actual=%0d,%0d,%b required=0,0,011", ifb.x, ifb.y,
                     {ifb.video_on, ifb.hsync, ifb.vsync});
        end
    endtask

    task automatic test_start();
        int sof_n;
        sof_n = 0;
        @(posedge clk);
        #1 ifa.en = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ifa.sof === 1'b1) sof_n++;
            checks++;
            if (ifa.p_tick !== ((k % 4) == 3)) begin
                failures++;
                $display("FAIL start_ptick clk=%0d actual=%b required=%b", k, ifa.p_tick, (k % 4) == 3);
            end
            if (k == 0) begin
                checks++;
                if ({ifa.sof, ifa.video_on, ifa.x} !== {2'b11, 11'd0}) begin
                    failures++;
                    $display("FAIL start_first sof,vo,x actual=%b,%b,%0d required=1,1,0",
                             ifa.sof, ifa.video_on, ifa.x);
                end
            end
            if (k == 3 || k == 4) begin
                checks++;
                if (ifa.x !== 11'((k == 4) ? 1 : 0)) begin
                    failures++;
                    $display("FAIL start_x clk=%0d actual=%0d required=%0d", k, ifa.x, (k == 4) ? 1 : 0);
                end
            end
        end
        checks++;
        if (sof_n != 1) begin
            failures++;
            $display("FAIL start_sof_count actual=%0d required=1", sof_n);
        end
    endtask

    task automatic test_line();
        int   vo_low, hs_low, vo_fx, hs_fx;
        logic prev_vo, prev_hs;
        bit   done;
        vo_low  = 0;
        hs_low  = 0;
        vo_fx   = -1;
        hs_fx   = -1;
        prev_vo = 1'b1;
        prev_hs = 1'b1;
        done    = 1'b0;
        for (int i = 0; i < 4000 && !done; i++) begin
            @(negedge clk);
            if (ifa.video_on === 1'b0) begin
                if (prev_vo) vo_fx = int'(ifa.x);
                vo_low++;
            end else if (!prev_vo) begin
                done = 1'b1;
            end
            if (ifa.hsync === 1'b0) begin
                if (prev_hs) hs_fx = int'(ifa.x);
                hs_low++;
            end
            prev_vo = ifa.video_on;
            prev_hs = ifa.hsync;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL line_timeout actual=no video_on return required=return within 4000 clks");
        end
        checks++;
        if (vo_fx != 640 || vo_low != 640) begin
            failures++;
            $display("FAIL line_blank start_x,clks actual=%0d,%0d required=640,640", vo_fx, vo_low);
        end
        checks++;
        if (hs_fx != 656 || hs_low != 384) begin
            failures++;
            $display("FAIL line_hsync start_x,clks actual=%0d,%0d required=656,384", hs_fx, hs_low);
        end
        checks++;
        if ({ifa.x, ifa.y} !== {11'd0, 11'd1}) begin
            failures++;
            $display("FAIL line_wrap actual=%0d,%0d required=0,1", ifa.x, ifa.y);
        end
        for (int j = 0; j < 3; j++) begin
            if (j > 0) @(negedge clk);
            checks++;
            if (ifa.video_on_d !== (j == 2)) begin
                failures++;
                $display("FAIL line_vod_delay step=%0d actual=%b required=%b", j, ifa.video_on_d, j == 2);
            end
        end
        @(posedge clk);
        #1 ifa.en = 1'b0;
    endtask

    task automatic test_frame();
        int   nsof, s0, s1, vs_fx, vs_fy, vs_low, px, py;
        logic prev_vs;
        logic [14:0] wrap_out;
        nsof = 0; s0 = -1; s1 = -1; vs_fx = -1; vs_fy = -1; vs_low = 0;
        px = -1; py = -1; prev_vs = 1'b1; wrap_out = '0;
        @(posedge clk);
        #1 ifb.en = 1'b1;
        @(posedge clk);
        for (int c = 0; c < 2000 && nsof < 2; c++) begin
            @(negedge clk);
            if (ifb.sof === 1'b1) begin
                if (nsof == 0) begin
                    s0 = c;
                end else begin
                    s1       = c;
                    wrap_out = {ifb.x, ifb.y, ifb.hsync, ifb.vsync, ifb.video_on};
                end
                nsof++;
            end
            if (nsof < 2) begin
                if (ifb.vsync === 1'b0) begin
                    if (prev_vs) begin
                        vs_fx = int'(ifb.x);
                        vs_fy = int'(ifb.y);
                    end
                    vs_low++;
                end
                px = int'(ifb.x);
                py = int'(ifb.y);
            end
            prev_vs = ifb.vsync;
        end
        checks++;
        if (nsof != 2 || s0 != 0) begin
            failures++;
            $display("FAIL frame_sof count,first actual=%0d,%0d required=2,0", nsof, s0);
        end
        checks++;
        if (s1 - s0 != 510) begin
            failures++;
            $display("FAIL frame_period actual=%0d required=510", s1 - s0);
        end
        checks++;
        if (vs_fx != 0 || vs_fy != 7 || vs_low != 102) begin
            failures++;
            $display("FAIL frame_vsync x,y,clks actual=%0d,%0d,%0d required=0,7,102", vs_fx, vs_fy, vs_low);
        end
        checks++;
        if (px != 16 || py != 9) begin
            failures++;
            $display("FAIL frame_prewrap actual=%0d,%0d required=16,9", px, py);
        end
        checks++;
        if (wrap_out !== {6'd0, 6'd0, 3'b111}) begin
            failures++;
            $display("FAIL frame_wrap x,y,hs,vs,vo actual=%h required=%h", wrap_out, {6'd0, 6'd0, 3'b111});
        end
    endtask

    task automatic test_en_toggle();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            @(negedge clk);
            if (ifb.x === 6'd7 && ifb.y === 6'd4) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL en_wait actual=not reached required=pixel 7,4 within 600 clks");
        end
        @(posedge clk);
        #1 ifb.en = 1'b0;
        @(negedge clk);
        checks++;
        if (ifb.p_tick !== 1'b0) begin
            failures++;
            $display("FAIL en_off_ptick actual=%b required=0", ifb.p_tick);
        end
        @(negedge clk);
        checks++;
        if ({ifb.x, ifb.y} !== 12'd0) begin
            failures++;
            $display("FAIL en_off_xy actual=%0d,%0d required=0,0", ifb.x, ifb.y);
        end
        checks++;
        if ({ifb.video_on, ifb.hsync, ifb.vsync, ifb.sof, ifb.p_tick,
             ifb.hsync_d, ifb.vsync_d, ifb.video_on_d} !== 8'b01100110) begin
            failures++;
            $display("FAIL en_off_flags actual=%b required=01100110",
                     {ifb.video_on, ifb.hsync, ifb.vsync, ifb.sof, ifb.p_tick,
                      ifb.hsync_d, ifb.vsync_d, ifb.video_on_d});
        end
        repeat (3) @(posedge clk);
        #1 ifb.en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({ifb.x, ifb.y, ifb.sof, ifb.video_on} !== {12'd0, 2'b11}) begin
            failures++;
            $display("FAIL en_restart x,y,sof,vo actual=%0d,%0d,%b,%b required=0,0,1,1",
                     ifb.x, ifb.y, ifb.sof, ifb.video_on);
        end
        @(negedge clk);
        checks++;
        if (ifb.sof !== 1'b0) begin
            failures++;
            $display("FAIL en_restart_sof2 actual=%b required=0", ifb.sof);
        end
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        #1 ifa.en = 1'b1;
        repeat (50) @(posedge clk);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({ifa.x, ifa.y} !== 22'd0) begin
            failures++;
            $display("FAIL areset_xy actual=%0d,%0d required=0,0", ifa.x, ifa.y);
        end
        checks++;
        if ({ifa.hsync, ifa.vsync, ifa.video_on, ifa.sof, ifa.p_tick,
             ifa.hsync_d, ifa.vsync_d, ifa.video_on_d} !== 8'b11000110) begin
            failures++;
            $display("FAIL areset_flags actual=%b required=11000110",
                     {ifa.hsync, ifa.vsync, ifa.video_on, ifa.sof, ifa.p_tick,
                      ifa.hsync_d, ifa.vsync_d, ifa.video_on_d});
        end
        checks++;
        if ({ifb.x, ifb.y, ifb.video_on, ifb.hsync_d} !== {12'd0, 2'b01}) begin
            failures++;
            $display("FAIL areset_b actual=%0d,%0d,%b,%b required=0,0,0,1",
                     ifb.x, ifb.y, ifb.video_on, ifb.hsync_d);
        end
        @(posedge clk);
        @(negedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({ifa.x, ifa.y, ifa.sof, ifa.video_on} !== {22'd0, 2'b11}) begin
            failures++;
            $display("FAIL areset_resume x,y,sof,vo actual=%0d,%0d,%b,%b required=0,0,1,1",
                     ifa.x, ifa.y, ifa.sof, ifa.video_on);
        end
        repeat (10) @(posedge clk);
        #1 ifa.en = 1'b0;
    endtask

    initial begin : main
        test_reset();
        test_start();
        test_line();
        test_frame();
        test_en_toggle();
        test_async_reset();
        repeat (4) @(posedge clk);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        failures++;
        $display("FAIL watchdog actual=time limit reached required=finish before 1000000ns");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_vga_sync_gen
`default_nettype wire

// File: doc/vga_sync_gen.md
# vga_sync_gen

Video timing generator at the head of the video subsystem pixel pipeline. Divides the system clock into a pixel tick and runs horizontal/vertical counters. Drives the x/y pixel coordinates consumed by the pattern generator and other frame cores, plus video_on, hsync and vsync. A parameterised delay line re-aligns the sync and blanking outputs with downstream registered pixel data.

## Interface
- CD, 11: coordinate width.
- HD, 640: horizontal display pixels.
- HF, 16: horizontal front porch.
- HR, 96: hsync pulse width.
- HB, 48: horizontal back porch.
- VD, 480: vertical display lines.
- VF, 10: vertical front porch.
- VR, 2: vsync pulse width.
- VB, 33: vertical back porch.
- CLK_DIV, 4: system clocks per pixel, ≥2. 100 MHz gives a 25 MHz pixel rate.
- SYNC_DLY, 2: clock cycles of delay on the *_d outputs, 0..7.

Ports:
- clk, input, 1: system clock.
- reset_n, input, 1: asynchronous, active-low reset.
- en, input, 1: timing enable. Low holds the generator idle.
- x, output, CD: current horizontal count, 0..HD+HF+HR+HB-1.
- y, output, CD: current vertical count, 0..VD+VF+VR+VB-1.
- p_tick, output, 1: high during the last clk of each pixel period.
- video_on, output, 1: (x<HD) && (y<VD) && en.
- hsync, output, 1: active low.
- vsync, output, 1: active low.
- sof, output, 1: one-clk pulse on the cycle x,y first equal (0,0) in a frame.
- hsync_d, output, 1: hsync delayed by SYNC_DLY clks.
- vsync_d, output, 1: vsync delayed by SYNC_DLY clks.
- video_on_d, output, 1: video_on delayed by SYNC_DLY clks.

## Operation
- Constants: HT = HD+HF+HR+HB = 800; VT = VD+VF+VR+VB = 525.
- Divider div counts 0..CLK_DIV-1 while en=1. p_tick = en && (div==CLK_DIV-1).
- On a clk edge with p_tick=1:
  - x increments.
  - When x=HT-1, x wraps to 0 and y increments.
  - When y=VT-1 at the same time, y wraps to 0.
- hsync=0 iff HD+HF ≤ x ≤ HD+HF+HR-1, i.e. 656..751.
- vsync=0 iff VD+VF ≤ y ≤ VD+VF+VR-1, i.e. 490..491.
- video_on, hsync and vsync are registered and computed from the next counter values, so they are always consistent with the x,y on the same cycle.
- Each (x,y) is held for exactly CLK_DIV clks.
- sof is high for the first clk of pixel (0,0): the clk after the wrap edge, or the first enabled clk after en rises.
- Idle state (en=0): x=0, y=0, div=0, video_on=0, hsync=1, vsync=1, p_tick=0, sof=0.
- en is sampled synchronously:
  - en 0→1: the first edge with en=1 starts pixel (0,0) with video_on=1 and sof=1.
  - en 1→0: the next edge returns to idle mid-frame with no partial-line completion.
- Delay line: SYNC_DLY-stage shift registers for hsync, vsync and video_on. SYNC_DLY=0 is a combinational pass-through. Default 2 matches a two-register pixel path downstream.

## Timing
- Reset values:
  - x=0, y=0, div=0.
  - p_tick=0, video_on=0, hsync=1, vsync=1, sof=0.
  - All delay stages: hsync/vsync stages=1, video_on stages=0.
- Reset asserted mid-frame clears everything immediately, asynchronously. Operation resumes at (0,0) on the first enabled edge after release.
- Latency from counters to *_d is exactly SYNC_DLY clks. No cycle-level skew between hsync_d, vsync_d and video_on_d.
- Frame period = HT·VT·CLK_DIV = 1,680,000 clks.
- Line period = HT·CLK_DIV = 3200 clks.
- Wrap corner: at (799,524) with p_tick=1, the next cycle is (0,0), vsync=1, hsync=1, video_on=1, sof=1.
- Counter width: CD bits must hold HT-1 and VT-1. This is an elaboration-time assertion.

## Structure
- Package vga_timing_pkg holds:
  - the default 640x480@60 constants;
  - derived HT/VT;
  - sync-window start/end localparams;
  - a typedef for the CD-bit coordinate.
- Sub-module sync_delay: parameterised N-stage shift register with a per-bit reset value. It is instantiated once for the 3-bit {hsync, vsync, video_on} bundle.

## Test plan
- Reset then en=1, CLK_DIV=4:
  - p_tick is high every 4th clk.
  - x reaches 1 at clk 4.
  - sof is high only on clk 0.
- Run one full line:
  - hsync low for exactly 96·4=384 clks, starting when x=656.
  - video_on low from x=640 through x=799.
- Run a full frame:
  - vsync low while y=490..491 (2·3200 clks).
  - The next sof is exactly 1,680,000 clks after the first.
  - Wrap (799,524)→(0,0) is checked.
- Deassert en at (300,200):
  - The next edge returns to idle values.
  - Reasserting en restarts at (0,0) with sof.
- Assert reset_n=0 asynchronously between clk edges mid-line:
  - All outputs take reset values before the next edge.
- SYNC_DLY=2: hsync_d, vsync_d and video_on_d equal hsync, vsync and video_on shifted by exactly 2 clks across a line boundary.
- SYNC_DLY=0: the *_d outputs are identical to the undelayed outputs.
